// File: rtl/seq_detect_arbiter.sv
// Shared "101" Mealy detector time-multiplexed over NCH serial channels by a
// round-robin arbiter; per-channel states and saturating match counters.
module seq_detect_arbiter #(
  parameter int NCH = 4,
  parameter int CW  = 8,
  localparam int SW = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] bit_in,
  input  logic          clr,
  input  logic [SW-1:0] rd_sel,
  output logic [NCH-1:0] ack,
  output logic          match,
  output logic [SW-1:0] match_ch,
  output logic [CW-1:0] rd_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT1  = 2'd1,
    GOT10 = 2'd2
  } det_state_t;

  det_state_t    state_reg [NCH];
  logic [CW-1:0] cnt_reg [NCH];
  logic [SW-1:0] last_reg;
  logic          match_reg;
  logic [SW-1:0] match_ch_reg;

  logic          gnt;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] cand;
  det_state_t    cur_state;
  det_state_t    state_next;
  logic          hit;
  logic          x;

  // Scan last+1 .. last+NCH; the SW-bit sum wraps naturally since NCH is a power of two.
  always_comb begin
    ack     = '0;
    gnt     = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (reset && !clr) begin
      for (int k = 1; k <= NCH; k++) begin
        cand = last_reg + SW'(k);
        if (!gnt && req[cand]) begin
          gnt     = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt) ack[gnt_idx] = 1'b1;
  end

  // Single shared next-state function applied to the granted channel only.
  always_comb begin
    cur_state  = state_reg[gnt_idx];
    x          = bit_in[gnt_idx];
    state_next = IDLE;
    hit        = 1'b0;
    case (cur_state)
      IDLE:    state_next = x ? GOT1 : IDLE;
      GOT1:    state_next = x ? GOT1 : GOT10;
      GOT10: begin
        state_next = x ? GOT1 : IDLE;
        hit        = x;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_reg[i] <= IDLE;
        cnt_reg[i]   <= '0;
      end
      last_reg     <= SW'(NCH - 1);
      match_reg    <= 1'b0;
      match_ch_reg <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        state_reg[i] <= IDLE;
        cnt_reg[i]   <= '0;
      end
      last_reg  <= SW'(NCH - 1);
      match_reg <= 1'b0;
    end else begin
      match_reg <= 1'b0;
      if (gnt) begin
        state_reg[gnt_idx] <= state_next;
        match_reg          <= hit;
        match_ch_reg       <= gnt_idx;
        last_reg           <= gnt_idx;
        if (hit && cnt_reg[gnt_idx] != '1)
          cnt_reg[gnt_idx] <= cnt_reg[gnt_idx] + 1'b1;
      end
    end
  end

  assign match    = match_reg;
  assign match_ch = match_ch_reg;
  assign rd_cnt   = cnt_reg[rd_sel];

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Bench for seq_detect_arbiter: directed vector table, hand-written corner
// sequences and a random run checked against a history-based reference model.
module tb_seq_detect_arbiter;
  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int SW  = 2;
  localparam int MAXCNT = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] req = '0;
  logic [NCH-1:0] bit_in = '0;
  logic           clr = 1'b0;
  logic [SW-1:0]  rd_sel = '0;
  logic [NCH-1:0] ack;
  logic           match;
  logic [SW-1:0]  match_ch;
  logic [CW-1:0]  rd_cnt;

  seq_detect_arbiter #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .clr(clr),
    .rd_sel(rd_sel), .ack(ack), .match(match), .match_ch(match_ch), .rd_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-channel bit history since last clear/reset.
  int             m_last;
  bit             hist [NCH][$];
  int             m_cnt [NCH];
  bit             e_match;
  int             e_match_ch;
  logic [NCH-1:0] seen_ack;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_clear();
    m_last = NCH - 1;
    for (int i = 0; i < NCH; i++) begin
      hist[i].delete();
      m_cnt[i] = 0;
    end
    e_match = 1'b0;
  endtask

  // Enter at posedge+1; leaves at the next posedge+1 after all checks.
  task automatic step(input logic [NCH-1:0] r, input logic [NCH-1:0] b,
                      input logic c, input logic [SW-1:0] rs, input string tag);
    int g;
    int n;
    logic [NCH-1:0] e_ack;
    req = r; bit_in = b; clr = c; rd_sel = rs;
    g = -1;
    e_ack = '0;
    if (!c) begin
      for (int k = 1; k <= NCH; k++) begin
        int ch;
        ch = (m_last + k) % NCH;
        if (g < 0 && r[ch]) g = ch;
      end
    end
    if (g >= 0) e_ack[g] = 1'b1;
    #4;
    seen_ack = ack;
    chk({tag, " ack"}, ack, e_ack);
    @(posedge clk);
    #1;
    if (c) begin
      model_clear();
    end else if (g >= 0) begin
      hist[g].push_back(b[g]);
      n = hist[g].size();
      e_match = (n >= 3) && hist[g][n-3] && !hist[g][n-2] && hist[g][n-1];
      e_match_ch = g;
      if (e_match && m_cnt[g] < MAXCNT) m_cnt[g]++;
      m_last = g;
    end else begin
      e_match = 1'b0;
    end
    chk({tag, " match"}, match, e_match);
    if (e_match) chk({tag, " match_ch"}, match_ch, e_match_ch);
    chk({tag, " rd_cnt"}, rd_cnt, m_cnt[rs]);
    $display("%s req=%b bit=%b clr=%b ack=%b match=%b ch=%0d rd_sel=%0d rd_cnt=%0d",
             tag, r, b, c, seen_ack, match, match_ch, rs, rd_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '1; bit_in = '1; clr = 1'b0;
    #2;
    chk("reset ack", ack, 0);
    chk("reset match", match, 0);
    chk("reset match_ch", match_ch, 0);
    chk("reset rd_cnt", rd_cnt, 0);
    @(posedge clk);
    #1;
    chk("reset hold match", match, 0);
    chk("reset hold ack", ack, 0);
    reset = 1'b1;
    req = '0; bit_in = '0;
    model_clear();
    e_match_ch = 0;
    $display("reset pulse done");
  endtask

  typedef struct {
    logic [NCH-1:0] r;
    logic [NCH-1:0] b;
    logic           c;
    logic [SW-1:0]  rs;
    logic [NCH-1:0] e_ack;
    logic           e_m;
    logic [SW-1:0]  e_ch;
    logic [CW-1:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(logic [NCH-1:0] r, logic [NCH-1:0] b, logic c, logic [SW-1:0] rs,
                              logic [NCH-1:0] ea, logic em, logic [SW-1:0] ech, logic [CW-1:0] ec);
    vec_t v;
    v.r = r; v.b = b; v.c = c; v.rs = rs;
    v.e_ack = ea; v.e_m = em; v.e_ch = ech; v.e_cnt = ec;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    int nm;
    // Single channel 1,0,1,0,1 then clear, then full rotation with ch1 fed 1,0,1.
    tbl[0]  = mk(4'b0001, 4'b0001, 0, 0, 4'b0001, 0, 0, 0);
    tbl[1]  = mk(4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 0, 0);
    tbl[2]  = mk(4'b0001, 4'b0001, 0, 0, 4'b0001, 1, 0, 1);
    tbl[3]  = mk(4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 0, 1);
    tbl[4]  = mk(4'b0001, 4'b0001, 0, 0, 4'b0001, 1, 0, 2);
    tbl[5]  = mk(4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 0, 0);
    tbl[6]  = mk(4'b1111, 4'b0000, 0, 1, 4'b0001, 0, 0, 0);
    tbl[7]  = mk(4'b1111, 4'b0010, 0, 1, 4'b0010, 0, 0, 0);
    tbl[8]  = mk(4'b1111, 4'b0000, 0, 1, 4'b0100, 0, 0, 0);
    tbl[9]  = mk(4'b1111, 4'b0000, 0, 1, 4'b1000, 0, 0, 0);
    tbl[10] = mk(4'b1111, 4'b0000, 0, 1, 4'b0001, 0, 0, 0);
    tbl[11] = mk(4'b1111, 4'b0000, 0, 1, 4'b0010, 0, 0, 0);
    tbl[12] = mk(4'b1111, 4'b0000, 0, 1, 4'b0100, 0, 0, 0);
    tbl[13] = mk(4'b1111, 4'b0000, 0, 1, 4'b1000, 0, 0, 0);
    tbl[14] = mk(4'b1111, 4'b0000, 0, 1, 4'b0001, 0, 0, 0);
    tbl[15] = mk(4'b1111, 4'b0010, 0, 1, 4'b0010, 1, 1, 1);
    tbl[16] = mk(4'b1111, 4'b0000, 0, 1, 4'b0100, 0, 0, 1);

    model_clear();
    e_match_ch = 0;
    #1;
    do_reset();

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].b, tbl[i].c, tbl[i].rs, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl ack", i), seen_ack, tbl[i].e_ack);
      chk($sformatf("vec%0d tbl match", i), match, tbl[i].e_m);
      if (tbl[i].e_m) chk($sformatf("vec%0d tbl match_ch", i), match_ch, tbl[i].e_ch);
      chk($sformatf("vec%0d tbl rd_cnt", i), rd_cnt, tbl[i].e_cnt);
    end

    // Round-robin fairness starting from last=1.
    step(4'b0000, 4'b0000, 1, 0, "fair clr");
    step(4'b0010, 4'b0000, 0, 0, "fair pre");
    for (int i = 0; i < 4; i++) begin
      step(4'b1010, 4'b0000, 0, 0, "fair rr");
      chk("fair rr order", seen_ack, (i % 2 == 0) ? 4'b1000 : 4'b0010);
    end
    for (int i = 0; i < 2; i++) begin
      step(4'b0010, 4'b0000, 0, 0, "fair solo");
      chk("fair solo ack", seen_ack, 4'b0010);
    end

    // Reset in the middle of a pattern on ch2.
    step(4'b0000, 4'b0000, 1, 2, "rst clr");
    step(4'b0100, 4'b0100, 0, 2, "rst b1");
    step(4'b0100, 4'b0000, 0, 2, "rst b0");
    do_reset();
    step(4'b0100, 4'b0100, 0, 2, "rst after1");
    chk("rst no match", match, 0);
    chk("rst cnt2", rd_cnt, 0);
    step(4'b0100, 4'b0000, 0, 2, "rst after0");
    step(4'b0100, 4'b0100, 0, 2, "rst after1b");
    chk("rst got1 proof match", match, 1);
    chk("rst got1 proof ch", match_ch, 2);

    // Clear colliding with a completing bit on ch0; ch3 holds a count first.
    step(4'b1000, 4'b1000, 0, 3, "clc c3a");
    step(4'b1000, 4'b0000, 0, 3, "clc c3b");
    step(4'b1000, 4'b1000, 0, 3, "clc c3c");
    chk("clc pre cnt3", rd_cnt, 1);
    step(4'b0001, 4'b0001, 0, 0, "clc c0a");
    step(4'b0001, 4'b0000, 0, 0, "clc c0b");
    step(4'b0001, 4'b0001, 1, 0, "clc hit");
    chk("clc ack", seen_ack, 0);
    chk("clc no match", match, 0);
    for (int s = 0; s < NCH; s++) begin
      step(4'b0000, 4'b0000, 0, SW'(s), "clc read");
      chk($sformatf("clc cnt%0d", s), rd_cnt, 0);
    end

    // Saturation: 20 matches on ch0 with a 4-bit counter.
    step(4'b0000, 4'b0000, 1, 0, "sat clr");
    step(4'b0001, 4'b0001, 0, 0, "sat lead");
    nm = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0001, 4'b0000, 0, 0, "sat 0");
      step(4'b0001, 4'b0001, 0, 0, "sat 1");
      if (match === 1'b1) nm++;
    end
    chk("sat match pulses", nm, 20);
    chk("sat rd_cnt", rd_cnt, MAXCNT);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(NCH'($urandom_range(0, 15)), NCH'($urandom_range(0, 15)),
           ($urandom_range(0, 24) == 0), SW'($urandom_range(0, NCH - 1)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
